multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 SHALL have clk_i, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have reset_i, input, 1, synchronous active-high reset.
REQ-003 SHALL have opcode_i, input, 7, opcode from instruction_decoder; funct3_i, input, 3; funct7_i, input, 7.
REQ-004 SHALL have branch_cond_i, input, 1, compare result from the datapath; high means branch taken.
REQ-005 SHALL have mem_ready_i, input, 1, data memory completion acknowledge.
REQ-006 SHALL have ir_write_o, pc_write_o, reg_write_o, mem_req_o, mem_write_o; each output, 1; strobes to instruction register, PC, register file and data memory.
REQ-007 SHALL have alu_control_o, output, 3; alu_src_o, output, 1 (0=rs2, 1=immediate); pc_src_o, output, 1 (0=PC+4, 1=target); wb_src_o, output, 2 (00=ALU, 01=memory, 10=PC+4, 11=immediate_u).
REQ-008 SHALL have mem_mode_o, output, 2 (00 byte, 01 halfword, 10 word), state_o, output, 3, and halt_o, output, 1 (sticky illegal-instruction flag).

Function
REQ-009 SHALL implement states FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP.
REQ-010 SHALL assert ir_write_o for exactly one cycle in FETCH and then go to DECODE.
REQ-011 SHALL go from DECODE to EXECUTE when the opcode is LOAD, STORE, OP-IMM, OP, LUI, BRANCH or JAL, and to TRAP otherwise.
REQ-012 SHALL go to TRAP from DECODE when a LOAD or STORE has funct3 outside 000/001/010.
REQ-013 SHALL drive alu_control_o in EXECUTE: ADD for LOAD, STORE and ADDI; ADD/SUB for OP selected by funct7[5]; AND/OR/SLT per funct3; SUB for BRANCH.
REQ-014 For BRANCH, SHALL in EXECUTE assert pc_write_o with pc_src_o=branch_cond_i, then return to FETCH (3 cycles).
REQ-015 For LOAD and STORE, SHALL go from EXECUTE to MEMORY and hold mem_req_o, mem_mode_o and mem_write_o (STORE only) stable until mem_ready_i is sampled high.
REQ-016 SHALL accept a zero-wait completion, where mem_ready_i is high in the first MEMORY cycle.
REQ-017 SHALL ignore mem_ready_i outside MEMORY.
REQ-018 For STORE, SHALL assert pc_write_o (pc_src_o=0) in the completing MEMORY cycle and go to FETCH; LOAD goes to WRITEBACK.
REQ-019 SHALL in WRITEBACK assert reg_write_o and pc_write_o for one cycle, then go to FETCH.
REQ-020 In WRITEBACK, SHALL use pc_src_o=1 only for JAL and wb_src_o per REQ-007.
REQ-021 SHALL give latency of 4 cycles for OP/OP-IMM/LUI/JAL, 5+N for LOAD and 4+N for STORE, where N = wait cycles.
REQ-022 SHALL keep reg_write_o, pc_write_o, ir_write_o and mem_req_o low in every state and opcode not listed above.
REQ-023 SHALL hold every strobe low in TRAP, keep halt_o high and remain in TRAP until reset.

Reset
REQ-024 On reset_i high at a clock edge, SHALL enter FETCH regardless of state, including mid-MEMORY and TRAP.
REQ-025 During and immediately after reset, SHALL drive all strobes 0, halt_o 0, alu_control_o 010 (ADD), other selects 0 and state_o = FETCH encoding.
REQ-026 SHALL abandon an outstanding memory request at reset with no write strobe issued.

Configuration
REQ-027 With CTRL_PERF_COUNTERS_EN defined, SHALL add outputs cycle_count_o[31:0] (+1 every non-reset cycle) and instret_o[31:0] (+1 on each pc_write_o cycle).
REQ-028 Both counters SHALL reset to 0, wrap from FFFFFFFF to 0 and freeze in TRAP.
REQ-029 Without CTRL_PERF_COUNTERS_EN, SHALL have neither the ports nor the counter logic.

Structure
REQ-030 The shared package SHALL hold the state enum, RV32I opcode constants, ALU control encodings (AND 000, OR 001, ADD 010, SUB 110, SLT 111), mem_mode and wb_src encodings.
REQ-031 The ALU-control mapping from opcode/funct3/funct7 SHALL be the sub-module alu_control_decoder, purely combinational.

Verification
REQ-032 Bench SHALL cover: ADDI (opcode 0010011) -> states F,D,E,WB; reg_write_o and pc_write_o high only in cycle 4; alu_control_o=010.
REQ-033 Bench SHALL cover: LW (funct3 010) with mem_ready_i delayed 3 cycles -> mem_req_o high 4 cycles, mem_mode_o=10, reg_write_o with wb_src_o=01 in cycle 8.
REQ-034 Bench SHALL cover: SB with mem_ready_i in the first MEMORY cycle -> mem_write_o high 1 cycle, mem_mode_o=00, pc_write_o in cycle 4, reg_write_o never high.
REQ-035 Bench SHALL cover: BEQ with branch_cond_i=1, then =0 -> pc_write_o in cycle 3 with pc_src_o=1, then 0.
REQ-036 Bench SHALL cover: opcode 1111111, or LOAD with funct3 011 -> TRAP after DECODE, halt_o=1, no strobes for 20 cycles, counters frozen.
REQ-037 Bench SHALL cover: reset_i pulsed during a MEMORY wait -> FETCH next cycle, mem_req_o=0, halt_o=0, counters=0.

Source files
------------

// File: rtl/multicycle_control_unit_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states, RV32I opcodes,
// ALU / memory-size / write-back select encodings and small decode helpers.
package multicycle_control_unit_pkg;

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_MEMORY    = 3'd3,
      ST_WRITEBACK = 3'd4,
      ST_TRAP      = 3'd5
   } state_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   localparam logic [1:0] WB_ALU   = 2'b00;
   localparam logic [1:0] WB_MEM   = 2'b01;
   localparam logic [1:0] WB_PC4   = 2'b10;
   localparam logic [1:0] WB_IMM_U = 2'b11;

   function automatic logic is_supported_opcode(input logic [6:0] op);
      return (op == OPC_LOAD)   || (op == OPC_STORE) || (op == OPC_OP_IMM) ||
             (op == OPC_OP)     || (op == OPC_LUI)   || (op == OPC_BRANCH) ||
             (op == OPC_JAL);
   endfunction

   // Only byte, halfword and word accesses exist; funct3 doubles as the size code.
   function automatic logic mem_funct3_ok(input logic [2:0] f3);
      return f3 <= 3'b010;
   endfunction

endpackage

// File: rtl/multicycle_control_unit_alu_control_decoder.sv
// Purely combinational ALU operation select from opcode/funct3/funct7.
module alu_control_decoder
   import multicycle_control_unit_pkg::*;
(
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   output logic [2:0] alu_control_o
);

   logic unused_funct7;
   assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

   always_comb begin
      alu_control_o = ALU_ADD;
      case (opcode_i)
         OPC_OP, OPC_OP_IMM: begin
            case (funct3_i)
               // funct7[5] only distinguishes SUB for register-register ops; ADDI has no SUB form
               3'b000:  alu_control_o = ((opcode_i == OPC_OP) && funct7_i[5]) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control_o = ALU_SLT;
               3'b110:  alu_control_o = ALU_OR;
               3'b111:  alu_control_o = ALU_AND;
               default: alu_control_o = ALU_ADD;
            endcase
         end
         OPC_BRANCH: alu_control_o = ALU_SUB;
         default:    alu_control_o = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I-subset control FSM (FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/TRAP).
// Optional performance counters are enabled by defining CTRL_PERF_COUNTERS_EN.
module multicycle_control_unit
   import multicycle_control_unit_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [6:0] opcode_i,
   input  logic [2:0] funct3_i,
   input  logic [6:0] funct7_i,
   input  logic       branch_cond_i,
   input  logic       mem_ready_i,
   output logic       ir_write_o,
   output logic       pc_write_o,
   output logic       reg_write_o,
   output logic       mem_req_o,
   output logic       mem_write_o,
   output logic [2:0] alu_control_o,
   output logic       alu_src_o,
   output logic       pc_src_o,
   output logic [1:0] wb_src_o,
   output logic [1:0] mem_mode_o,
   output logic [2:0] state_o,
   output logic       halt_o
`ifdef CTRL_PERF_COUNTERS_EN
   ,
   output logic [31:0] cycle_count_o,
   output logic [31:0] instret_o
`endif
);

   state_e     state_q;
   logic       ir_write_q, pc_write_q, reg_write_q, mem_req_q, mem_write_q;
   logic       alu_src_q, pc_src_q, halt_q, branch_q;
   logic [2:0] alu_control_q;
   logic [1:0] wb_src_q, mem_mode_q;

   logic       is_load, is_store, is_op_imm, is_branch, is_jal, is_lui, legal;
   logic       store_done;
   logic [2:0] alu_dec;

   assign is_load   = (opcode_i == OPC_LOAD);
   assign is_store  = (opcode_i == OPC_STORE);
   assign is_op_imm = (opcode_i == OPC_OP_IMM);
   assign is_branch = (opcode_i == OPC_BRANCH);
   assign is_jal    = (opcode_i == OPC_JAL);
   assign is_lui    = (opcode_i == OPC_LUI);
   assign legal     = is_supported_opcode(opcode_i) &&
                      (!(is_load || is_store) || mem_funct3_ok(funct3_i));

   alu_control_decoder u_alu_control_decoder (
      .opcode_i      (opcode_i),
      .funct3_i      (funct3_i),
      .funct7_i      (funct7_i),
      .alu_control_o (alu_dec)
   );

   // Outputs are registered alongside the state they belong to; the first FETCH after
   // reset is a quiet cycle that arms ir_write for the following FETCH cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_FETCH;
         ir_write_q    <= 1'b0;
         pc_write_q    <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_mode_q    <= MEM_BYTE;
         alu_control_q <= ALU_ADD;
         alu_src_q     <= 1'b0;
         pc_src_q      <= 1'b0;
         wb_src_q      <= WB_ALU;
         halt_q        <= 1'b0;
         branch_q      <= 1'b0;
      end else begin
         ir_write_q    <= 1'b0;
         pc_write_q    <= 1'b0;
         reg_write_q   <= 1'b0;
         mem_req_q     <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_mode_q    <= MEM_BYTE;
         alu_control_q <= ALU_ADD;
         alu_src_q     <= 1'b0;
         pc_src_q      <= 1'b0;
         wb_src_q      <= WB_ALU;
         branch_q      <= 1'b0;
         case (state_q)
            ST_FETCH: begin
               if (ir_write_q) begin
                  state_q <= ST_DECODE;
               end else begin
                  ir_write_q <= 1'b1;
               end
            end
            ST_DECODE: begin
               if (!legal) begin
                  state_q <= ST_TRAP;
                  halt_q  <= 1'b1;
               end else begin
                  state_q       <= ST_EXECUTE;
                  alu_control_q <= alu_dec;
                  alu_src_q     <= is_load || is_store || is_op_imm;
                  pc_write_q    <= is_branch;
                  branch_q      <= is_branch;
               end
            end
            ST_EXECUTE: begin
               if (is_branch) begin
                  state_q    <= ST_FETCH;
                  ir_write_q <= 1'b1;
               end else if (is_load || is_store) begin
                  state_q     <= ST_MEMORY;
                  mem_req_q   <= 1'b1;
                  mem_write_q <= is_store;
                  mem_mode_q  <= funct3_i[1:0];
               end else begin
                  state_q     <= ST_WRITEBACK;
                  reg_write_q <= 1'b1;
                  pc_write_q  <= 1'b1;
                  pc_src_q    <= is_jal;
                  wb_src_q    <= is_jal ? WB_PC4 : (is_lui ? WB_IMM_U : WB_ALU);
               end
            end
            ST_MEMORY: begin
               if (mem_ready_i) begin
                  if (mem_write_q) begin
                     state_q    <= ST_FETCH;
                     ir_write_q <= 1'b1;
                  end else begin
                     state_q     <= ST_WRITEBACK;
                     reg_write_q <= 1'b1;
                     pc_write_q  <= 1'b1;
                     wb_src_q    <= WB_MEM;
                  end
               end else begin
                  mem_req_q   <= mem_req_q;
                  mem_write_q <= mem_write_q;
                  mem_mode_q  <= mem_mode_q;
               end
            end
            ST_WRITEBACK: begin
               state_q    <= ST_FETCH;
               ir_write_q <= 1'b1;
            end
            ST_TRAP: begin
               state_q <= ST_TRAP;
            end
            default: begin
               state_q <= ST_TRAP;
               halt_q  <= 1'b1;
            end
         endcase
      end
   end

   // A store retires in the very cycle memory acknowledges, and a branch resolves on the
   // live compare result, so those two terms bypass the output registers.
   assign store_done    = (state_q == ST_MEMORY) && mem_write_q && mem_ready_i;

   assign ir_write_o    = !reset_i && ir_write_q;
   assign pc_write_o    = !reset_i && (pc_write_q || store_done);
   assign reg_write_o   = !reset_i && reg_write_q;
   assign mem_req_o     = !reset_i && mem_req_q;
   assign mem_write_o   = !reset_i && mem_write_q;
   assign alu_control_o = reset_i ? ALU_ADD : alu_control_q;
   assign alu_src_o     = !reset_i && alu_src_q;
   assign pc_src_o      = !reset_i && (branch_q ? branch_cond_i : pc_src_q);
   assign wb_src_o      = reset_i ? WB_ALU : wb_src_q;
   assign mem_mode_o    = reset_i ? MEM_BYTE : mem_mode_q;
   assign state_o       = reset_i ? ST_FETCH : state_q;
   assign halt_o        = !reset_i && halt_q;

`ifdef CTRL_PERF_COUNTERS_EN
   logic [31:0] cycle_count_q, cycle_count_d, instret_q, instret_d;

   // Both counters stop advancing once the unit has trapped.
   always_comb begin
      cycle_count_d = cycle_count_q;
      instret_d     = instret_q;
      if (state_q != ST_TRAP) begin
         cycle_count_d = cycle_count_q + 32'd1;
         if (pc_write_o) begin
            instret_d = instret_q + 32'd1;
         end else begin
            instret_d = instret_q;
         end
      end else begin
         cycle_count_d = cycle_count_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cycle_count_q <= 32'd0;
         instret_q     <= 32'd0;
      end else begin
         cycle_count_q <= cycle_count_d;
         instret_q     <= instret_d;
      end
   end

   assign cycle_count_o = cycle_count_q;
   assign instret_o     = instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit with an instruction-level reference model.
module tb_multicycle_control_unit;
   import multicycle_control_unit_pkg::*;

   logic       clk_i = 1'b0;
   logic       reset_i = 1'b1;
   logic [6:0] opcode_i = 7'd0;
   logic [2:0] funct3_i = 3'd0;
   logic [6:0] funct7_i = 7'd0;
   logic       branch_cond_i = 1'b0;
   logic       mem_ready_i = 1'b0;
   logic       ir_write_o, pc_write_o, reg_write_o, mem_req_o, mem_write_o;
   logic [2:0] alu_control_o;
   logic       alu_src_o, pc_src_o;
   logic [1:0] wb_src_o, mem_mode_o;
   logic [2:0] state_o;
   logic       halt_o;
`ifdef CTRL_PERF_COUNTERS_EN
   logic [31:0] cycle_count_o, instret_o;
`endif

   always #5 clk_i = ~clk_i;

   multicycle_control_unit dut (
      .clk_i(clk_i), .reset_i(reset_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
      .funct7_i(funct7_i), .branch_cond_i(branch_cond_i), .mem_ready_i(mem_ready_i),
      .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .reg_write_o(reg_write_o),
      .mem_req_o(mem_req_o), .mem_write_o(mem_write_o), .alu_control_o(alu_control_o),
      .alu_src_o(alu_src_o), .pc_src_o(pc_src_o), .wb_src_o(wb_src_o),
      .mem_mode_o(mem_mode_o), .state_o(state_o), .halt_o(halt_o)
`ifdef CTRL_PERF_COUNTERS_EN
      , .cycle_count_o(cycle_count_o), .instret_o(instret_o)
`endif
   );

   localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_OPIMM = 7'b0010011;
   localparam logic [6:0] T_OP = 7'b0110011, T_LUI = 7'b0110111, T_BR = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111;
   localparam int K_ALU = 0, K_LUI = 1, K_JAL = 2, K_LOAD = 3, K_STORE = 4, K_BR = 5, K_ILL = 6;
   localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_WB = 4, P_T = 5;

   int checks = 0;
   int failures = 0;

   int ph = P_F;
   bit idle = 1'b1;
   int mem_cnt = 0;
   int idx = 0;
   logic [31:0] m_cyc = 32'd0, m_ins = 32'd0;
   bit cnt_valid = 1'b0;
   logic [6:0] cur_op = 7'd0;
   logic [2:0] cur_f3 = 3'd0;
   logic [6:0] cur_f7 = 7'd0;
   int cur_wait = 0;
   int bc_force = -1;
   bit rst_drv = 1'b1;

   int n_regwr, regw_at, pcw_at, n_memreq, n_memwr;
   logic pcsrc_at_pcw;
   logic [1:0] wb_at_regw, mode_seen;
   logic [2:0] alu_at_e;
   logic [6:0] ops [0:6];

   function automatic int kind_of(input logic [6:0] op, input logic [2:0] f3);
      case (op)
         T_OPIMM, T_OP: return K_ALU;
         T_LUI:         return K_LUI;
         T_JAL:         return K_JAL;
         T_BR:          return K_BR;
         T_LOAD:        return (f3 <= 3'd2) ? K_LOAD : K_ILL;
         T_STORE:       return (f3 <= 3'd2) ? K_STORE : K_ILL;
         default:       return K_ILL;
      endcase
   endfunction

   function automatic logic [2:0] exp_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
      int k;
      k = kind_of(op, f3);
      if (k == K_BR) return 3'b110;
      if (k == K_ALU) begin
         if (f3 == 3'b111) return 3'b000;
         if (f3 == 3'b110) return 3'b001;
         if (f3 == 3'b010) return 3'b111;
         if (f3 == 3'b000 && op == T_OP && f7[5]) return 3'b110;
      end
      return 3'b010;
   endfunction

   function automatic logic [2:0] st_of(input int p);
      case (p)
         P_F:     return ST_FETCH;
         P_D:     return ST_DECODE;
         P_E:     return ST_EXECUTE;
         P_M:     return ST_MEMORY;
         P_WB:    return ST_WRITEBACK;
         default: return ST_TRAP;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // One clock cycle: drive inputs, compare every output against the model, advance the model.
   task automatic step();
      int k;
      logic e_ir, e_pcw, e_rw, e_mreq, e_mwr, e_asrc, e_psrc, e_halt;
      logic [2:0] e_alu, e_st;
      logic [1:0] e_wb, e_mode;
      @(posedge clk_i);
      #1;
      reset_i  = rst_drv;
      opcode_i = cur_op;
      funct3_i = cur_f3;
      funct7_i = cur_f7;
      branch_cond_i = (bc_force < 0) ? 1'($urandom) : (bc_force != 0);
      if (!rst_drv && ph == P_M) mem_ready_i = (mem_cnt == cur_wait);
      else mem_ready_i = 1'($urandom);
      @(negedge clk_i);
      k = kind_of(cur_op, cur_f3);
      e_ir = 1'b0; e_pcw = 1'b0; e_rw = 1'b0; e_mreq = 1'b0; e_mwr = 1'b0;
      e_asrc = 1'b0; e_psrc = 1'b0; e_alu = 3'b010; e_wb = 2'b00; e_mode = 2'b00;
      e_st = st_of(ph);
      e_halt = (ph == P_T);
      if (rst_drv) begin
         e_st = st_of(P_F);
         e_halt = 1'b0;
      end else begin
         case (ph)
            P_F: e_ir = !idle;
            P_E: begin
               e_alu  = exp_alu(cur_op, cur_f3, cur_f7);
               e_asrc = (k == K_LOAD) || (k == K_STORE) || (cur_op == T_OPIMM);
               if (k == K_BR) begin
                  e_pcw  = 1'b1;
                  e_psrc = branch_cond_i;
               end
            end
            P_M: begin
               e_mreq = 1'b1;
               e_mwr  = (k == K_STORE);
               e_mode = cur_f3[1:0];
               if (k == K_STORE && mem_ready_i) e_pcw = 1'b1;
            end
            P_WB: begin
               e_rw   = 1'b1;
               e_pcw  = 1'b1;
               e_psrc = (k == K_JAL);
               e_wb   = (k == K_LOAD) ? 2'b01 : (k == K_JAL) ? 2'b10 : (k == K_LUI) ? 2'b11 : 2'b00;
            end
            default: ;
         endcase
      end
      chk("ir_write", 32'(ir_write_o), 32'(e_ir));
      chk("pc_write", 32'(pc_write_o), 32'(e_pcw));
      chk("reg_write", 32'(reg_write_o), 32'(e_rw));
      chk("mem_req", 32'(mem_req_o), 32'(e_mreq));
      chk("mem_write", 32'(mem_write_o), 32'(e_mwr));
      chk("alu_control", 32'(alu_control_o), 32'(e_alu));
      chk("alu_src", 32'(alu_src_o), 32'(e_asrc));
      chk("pc_src", 32'(pc_src_o), 32'(e_psrc));
      chk("wb_src", 32'(wb_src_o), 32'(e_wb));
      chk("mem_mode", 32'(mem_mode_o), 32'(e_mode));
      chk("state", 32'(state_o), 32'(e_st));
      chk("halt", 32'(halt_o), 32'(e_halt));
`ifdef CTRL_PERF_COUNTERS_EN
      if (cnt_valid) begin
         chk("cycle_count", cycle_count_o, m_cyc);
         chk("instret", instret_o, m_ins);
      end
`endif
      if (!rst_drv) begin
         if (reg_write_o) begin n_regwr++; regw_at = idx; wb_at_regw = wb_src_o; end
         if (pc_write_o) begin pcw_at = idx; pcsrc_at_pcw = pc_src_o; end
         if (mem_req_o) begin n_memreq++; mode_seen = mem_mode_o; end
         if (mem_write_o) n_memwr++;
         if (ph == P_E) alu_at_e = alu_control_o;
      end
      if (rst_drv) begin
         ph = P_F; idle = 1'b1; m_cyc = 32'd0; m_ins = 32'd0; cnt_valid = 1'b1;
      end else begin
         if (ph != P_T) begin
            m_cyc = m_cyc + 32'd1;
            if (e_pcw) m_ins = m_ins + 32'd1;
         end
         idx++;
         case (ph)
            P_F:  if (idle) idle = 1'b0; else ph = P_D;
            P_D:  ph = (k == K_ILL) ? P_T : P_E;
            P_E: begin
               if (k == K_BR) ph = P_F;
               else if (k == K_LOAD || k == K_STORE) begin ph = P_M; mem_cnt = 0; end
               else ph = P_WB;
            end
            P_M:  if (mem_ready_i) ph = (k == K_STORE) ? P_F : P_WB; else mem_cnt++;
            P_WB: ph = P_F;
            default: ;
         endcase
      end
   endtask

   task automatic do_reset();
      rst_drv = 1'b1;
      step();
      step();
      rst_drv = 1'b0;
      step();
   endtask

   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input int wait_n, input int bc, input int rst_at);
      int guard;
      guard = 0;
      cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_wait = wait_n; bc_force = bc;
      idx = 1; n_regwr = 0; regw_at = 0; pcw_at = 0; n_memreq = 0; n_memwr = 0;
      pcsrc_at_pcw = 1'b0; wb_at_regw = 2'b00; mode_seen = 2'b00; alu_at_e = 3'b000;
      do begin
         if (rst_at >= 0 && ph == P_M && mem_cnt == rst_at) begin
            rst_drv = 1'b1;
            step();
            rst_drv = 1'b0;
            step();
            return;
         end
         step();
         guard++;
      end while (ph != P_F && ph != P_T && guard < 200);
      if (guard >= 200) begin
         checks++;
         failures++;
         $display("FAIL instr_timeout: opcode %b still running after %0d cycles", op, guard);
      end
      if (ph == P_T) begin
         for (int i = 0; i < 20; i++) step();
         chk("trap_halt_sticky", 32'(halt_o), 32'd1);
         chk("trap_state_hold", 32'(state_o), 32'd5);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      ops[0] = T_LOAD; ops[1] = T_STORE; ops[2] = T_OPIMM; ops[3] = T_OP;
      ops[4] = T_LUI;  ops[5] = T_BR;    ops[6] = T_JAL;
      do_reset();
      chk("reset_state", 32'(state_o), 32'd0);

      run_instr(T_OPIMM, 3'b000, 7'd0, 0, -1, -1);
      chk("addi_regw_at", 32'(regw_at), 32'd4);
      chk("addi_pcw_at", 32'(pcw_at), 32'd4);
      chk("addi_regw_count", 32'(n_regwr), 32'd1);
      chk("addi_alu", 32'(alu_at_e), 32'h2);

      run_instr(T_LOAD, 3'b010, 7'd0, 3, -1, -1);
      chk("lw_memreq_cycles", 32'(n_memreq), 32'd4);
      chk("lw_mode", 32'(mode_seen), 32'h2);
      chk("lw_regw_at", 32'(regw_at), 32'd8);
      chk("lw_wb_src", 32'(wb_at_regw), 32'h1);

      run_instr(T_STORE, 3'b000, 7'd0, 0, -1, -1);
      chk("sb_memwr_cycles", 32'(n_memwr), 32'd1);
      chk("sb_mode", 32'(mode_seen), 32'h0);
      chk("sb_pcw_at", 32'(pcw_at), 32'd4);
      chk("sb_regw_count", 32'(n_regwr), 32'd0);

      run_instr(T_BR, 3'b000, 7'd0, 0, 1, -1);
      chk("beq_taken_pcw_at", 32'(pcw_at), 32'd3);
      chk("beq_taken_pc_src", 32'(pcsrc_at_pcw), 32'd1);
      run_instr(T_BR, 3'b000, 7'd0, 0, 0, -1);
      chk("beq_not_taken_pcw_at", 32'(pcw_at), 32'd3);
      chk("beq_not_taken_pc_src", 32'(pcsrc_at_pcw), 32'd0);

      run_instr(T_OP, 3'b000, 7'b0100000, 0, -1, -1);
      chk("sub_alu", 32'(alu_at_e), 32'h6);
      run_instr(T_JAL, 3'b000, 7'd0, 0, -1, -1);
      chk("jal_pc_src", 32'(pcsrc_at_pcw), 32'd1);
      chk("jal_wb_src", 32'(wb_at_regw), 32'h2);
      run_instr(T_LUI, 3'b000, 7'd0, 0, -1, -1);
      chk("lui_wb_src", 32'(wb_at_regw), 32'h3);

      run_instr(T_LOAD, 3'b010, 7'd0, 10, -1, 2);
      chk("reset_mid_mem_req_cycles", 32'(n_memreq), 32'd2);
      chk("reset_mid_mem_state", 32'(state_o), 32'd0);
      chk("reset_mid_mem_halt", 32'(halt_o), 32'd0);

      run_instr(7'b1111111, 3'b000, 7'd0, 0, -1, -1);
      do_reset();
      run_instr(T_LOAD, 3'b011, 7'd0, 0, -1, -1);
      do_reset();

      for (int n = 0; n < 200; n++) begin
         logic [6:0] op;
         logic [2:0] f3;
         int w, ra;
         op = (($urandom_range(0, 99)) < 3) ? 7'b0001111 : ops[$urandom_range(0, 6)];
         f3 = 3'($urandom);
         w  = $urandom_range(0, 4);
         ra = -1;
         if (op == T_LOAD || op == T_STORE) begin
            f3 = ($urandom_range(0, 19) == 0) ? 3'd5 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 14) == 0) begin
               w  = 6;
               ra = $urandom_range(0, 5);
            end
         end
         run_instr(op, f3, 7'($urandom), w, -1, ra);
         if (ph == P_T) do_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
